pipelined_barrel_shifter: RTL
=============================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL be a power of two, >= 4.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; derived, not overridden.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  input word present.
REQ-006 Port in_ready  output  1  shifter can accept input this cycle.
REQ-007 Port in_data  input  WIDTH  operand.
REQ-008 Port in_amt  input  SHW  shift/rotate amount, 0..WIDTH-1.
REQ-009 Port in_mode  input  2  00 rotate right, 01 rotate left, 10 logical shift right, 11 arithmetic shift right.
REQ-010 Port out_valid  output  1  out_data holds a result.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port out_data  output  WIDTH  shifted/rotated result.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-014 SHW pipeline stages; stage k (k = 0..SHW-1) applies a 2^k-position move when amt bit k is set, else passes data unchanged.
REQ-015 Each stage register carries data, remaining amt bits, mode and a valid bit.
REQ-016 Latency: a word accepted in cycle N appears with out_valid=1 in cycle N+SHW when no stall occurs.
REQ-017 Throughput: one word per cycle while out_ready=1.
REQ-018 Stall: when out_valid=1 and out_ready=0, all stage registers hold and in_ready=0; in_ready = !(out_valid && !out_ready).
REQ-019 Pipeline bubbles propagate as valid=0; a bubble stage never blocks upstream stages unless REQ-018 applies.
REQ-020 Rotate modes: no bits lost; bits exiting one end re-enter at the other.
REQ-021 Logical right shift fills vacated MSBs with 0; arithmetic right shift fills with in_data[WIDTH-1] (sign carried through every stage).
REQ-022 in_amt = 0: out_data equals in_data for all modes, same latency.
REQ-023 in_amt = WIDTH-1: rotate right equals rotate left by 1; logical shift right leaves only original MSB in bit 0; arithmetic shift right yields all-ones or all-zeros from the sign.
REQ-024 in_data/in_amt/in_mode are ignored when no input transfer occurs.
REQ-025 out_data is don't-care when out_valid=0, but is registered (no combinational path from inputs to out_data).

Reset
REQ-026 rst_n low asynchronously clears all stage valid bits: out_valid=0, in_ready=1, out_data=0.
REQ-027 Reset mid-operation discards every in-flight word; no result from before reset is ever output after reset.
REQ-028 First input transfer is possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 Mode encodings (MODE_ROR, MODE_ROL, MODE_LSR, MODE_ASR) SHALL live in shared package barrel_pkg.
REQ-030 One sub-module, barrel_stage, parameterised by WIDTH and stage index; it implements a single 2^k move plus its pipeline register with hold enable. The top generates SHW instances of it.
REQ-031 Top-level logic is limited to handshake/stall generation and instance chaining.

Verification (WIDTH=8, latency 3)
REQ-032 Rotate right: in_data=0xB4, amt=3, mode=00 -> out_data=0x96 exactly 3 cycles after acceptance.
REQ-033 Back-to-back modes: 0xB4 amt 3 with modes 01, 10, 11 in consecutive cycles -> outputs 0xA5, 0x16, 0xF6 on consecutive cycles, in order.
REQ-034 Stall: hold out_ready=0 for 4 cycles with 3 words in flight -> in_ready=0, out_data stable; after release, words drain one per cycle, none lost or duplicated.
REQ-035 Boundaries: amt=0 on 0x5A, any mode -> 0x5A; amt=7 with mode 11 on 0x80 -> 0xFF; amt=7 with mode 10 on 0x80 -> 0x01.
REQ-036 Reset mid-stream: assert rst_n low with 2 words in flight -> out_valid=0 immediately; no stale words after release.
REQ-037 Random stream of 1000 words with random out_ready -> all outputs match a reference model, in order.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter.
package barrel_pkg;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_ROL = 2'b01,
    MODE_LSR = 2'b10,
    MODE_ASR = 2'b11
  } mode_e;

endpackage : barrel_pkg

// File: rtl/barrel_stage.sv
// One pipeline stage: conditionally moves the operand by 2**STAGE positions
// (direction and fill chosen by mode), then registers data, amount, mode and
// valid. The whole register holds when en_i is low.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGE = 0,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  input  mode_e            mode_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   amt_o,
  output mode_e            mode_o
);

  localparam int unsigned S = 1 << STAGE;

  logic [WIDTH-1:0] moved;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   amt_q,   amt_d;
  mode_e            mode_q,  mode_d;

  // Apply this stage's fixed-distance move when its amount bit is set.
  // ASR takes the fill from the current MSB; every earlier ASR stage has
  // preserved it, so it is still the original sign.
  always_comb begin
    moved = data_i;
    if (amt_i[STAGE]) begin
      unique case (mode_i)
        MODE_ROR: moved = (data_i >> S) | (data_i << (WIDTH - S));
        MODE_ROL: moved = (data_i << S) | (data_i >> (WIDTH - S));
        MODE_LSR: moved = data_i >> S;
        MODE_ASR: moved = $signed(data_i) >>> S;
        default:  moved = data_i;
      endcase
    end
  end

  // Next-state: load the moved word when enabled, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = moved;
      amt_d   = amt_i;
      mode_d  = mode_i;
    end
  end

  // Stage register; reset drops any word held here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= MODE_ROR;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign mode_o  = mode_q;

endmodule : barrel_stage

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter / rotator: SHW stages, one bit of the amount
// resolved per stage, valid/ready handshake with a global stall.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 4");
  end
  if (SHW != $clog2(WIDTH)) begin : g_bad_shw
    $error("pipelined_barrel_shifter: SHW must equal clog2(WIDTH)");
  end

  logic             advance;
  logic [SHW:0]     v_pipe;
  logic [WIDTH-1:0] d_pipe [SHW+1];
  logic [SHW-1:0]   a_pipe [SHW+1];
  mode_e            m_pipe [SHW+1];

  // Stall only when a result is waiting and downstream refuses it; bubbles
  // elsewhere never block, since every stage advances together.
  always_comb begin
    advance   = !(v_pipe[SHW] && !out_ready);
    in_ready  = advance;
    out_valid = v_pipe[SHW];
    out_data  = d_pipe[SHW];
  end

  assign v_pipe[0] = in_valid;
  assign d_pipe[0] = in_data;
  assign a_pipe[0] = in_amt;
  assign m_pipe[0] = mode_e'(in_mode);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .STAGE (k),
      .SHW   (SHW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (advance),
      .valid_i (v_pipe[k]),
      .data_i  (d_pipe[k]),
      .amt_i   (a_pipe[k]),
      .mode_i  (m_pipe[k]),
      .valid_o (v_pipe[k+1]),
      .data_o  (d_pipe[k+1]),
      .amt_o   (a_pipe[k+1]),
      .mode_o  (m_pipe[k+1])
    );
  end

endmodule : pipelined_barrel_shifter
